// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main sequencer for the multicycle processor datapath.
// Walks FETCH/DECODE/EXECUTE/WRITEBACK states, latches the condition result
// once per instruction and gates every architectural write with it.
// Supports memory wait states and counts retired instructions.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   Op, Funct, Rd     instruction fields [27:26], [25:20], destination reg
//   CondEx            condition-check result from the flag logic
//   MemReady          memory completes the access this cycle
//   IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl   datapath controls
//   PCWrite, RegWrite, MemWrite, FlagWrite                     gated write enables
//   Undef             pulse while decoding an undefined Op
//   State             current state code
//   InstrCount        retired-instruction counter (wraps)
module multicycle_ctrl #(
  parameter int unsigned CNT_W      = 32,
  parameter bit          FETCH_WAIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic [3:0]       Rd,
  input  logic             CondEx,
  input  logic             MemReady,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUControl,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [1:0]       FlagWrite,
  output logic             Undef,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_cond;
  logic [CNT_W-1:0] r_cnt;
  logic             w_retire;
  logic             w_fetch_go;

  logic       w_irw, w_adr, w_aluop, w_nextpc, w_regw, w_memw, w_branch, w_undef;
  logic [1:0] w_sa, w_sb, w_rs;
  logic [1:0] w_alu_dec;
  logic       w_alu_known;
  logic [1:0] w_aluc;
  logic [1:0] w_flagw;
  logic       w_pcs;

  assign w_fetch_go = FETCH_WAIT ? MemReady : 1'b1;

  // Next state and retirement detection
  always_comb begin
    w_next   = S_FETCH;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH:  w_next = w_fetch_go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          2'b00:   w_next = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_retire = 1'b1;
      S_MEMWR: begin
        w_next   = MemReady ? S_FETCH : S_MEMWR;
        w_retire = MemReady;
      end
      S_EXECR,
      S_EXECI:  w_next = S_ALUWB;
      S_ALUWB:  w_retire = 1'b1;
      S_BRANCH: w_retire = 1'b1;
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_cond  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_cond <= CondEx;
      if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Raw per-state decodes before condition gating
  always_comb begin
    w_irw    = 1'b0;
    w_adr    = 1'b0;
    w_sa     = 2'b00;
    w_sb     = 2'b00;
    w_rs     = 2'b00;
    w_aluop  = 1'b0;
    w_nextpc = 1'b0;
    w_regw   = 1'b0;
    w_memw   = 1'b0;
    w_branch = 1'b0;
    w_undef  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_sa     = 2'b01;
        w_sb     = 2'b10;
        w_rs     = 2'b10;
        w_irw    = w_fetch_go;
        w_nextpc = w_fetch_go;
      end
      S_DECODE: begin
        w_sa    = 2'b01;
        w_sb    = 2'b10;
        w_rs    = 2'b10;
        w_undef = (Op == 2'b11);
      end
      S_MEMADR: w_sb = 2'b01;
      S_MEMRD:  w_adr = 1'b1;
      S_MEMWB: begin
        w_rs   = 2'b01;
        w_regw = 1'b1;
      end
      S_MEMWR: begin
        w_adr  = 1'b1;
        w_memw = 1'b1;
      end
      S_EXECR: w_aluop = 1'b1;
      S_EXECI: begin
        w_sb    = 2'b01;
        w_aluop = 1'b1;
      end
      S_ALUWB: w_regw = 1'b1;
      S_BRANCH: begin
        w_sb     = 2'b01;
        w_rs     = 2'b10;
        w_branch = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decode; unrecognised function codes fall back to ADD without flags
  always_comb begin
    w_alu_dec   = 2'b00;
    w_alu_known = 1'b1;
    case (Funct[4:1])
      4'b0100: w_alu_dec = 2'b00;
      4'b0010: w_alu_dec = 2'b01;
      4'b0000: w_alu_dec = 2'b10;
      4'b1100: w_alu_dec = 2'b11;
      default: w_alu_known = 1'b0;
    endcase
  end

  assign w_aluc  = w_aluop ? w_alu_dec : 2'b00;
  assign w_flagw = (w_aluop && w_alu_known) ?
                   {Funct[0], Funct[0] & ~w_alu_dec[1]} : 2'b00;
  assign w_pcs   = w_branch | (w_regw & (Rd == 4'd15));

  // Reset masks every enable so nothing is written while reset is held
  assign IRWrite    = w_irw & reset;
  assign AdrSrc     = w_adr;
  assign ALUSrcA    = w_sa;
  assign ALUSrcB    = w_sb;
  assign ResultSrc  = w_rs;
  assign ALUControl = w_aluc;
  assign PCWrite    = (w_nextpc | (w_pcs & r_cond)) & reset;
  assign RegWrite   = w_regw & r_cond & reset;
  assign MemWrite   = w_memw & r_cond & reset;
  assign FlagWrite  = w_flagw & {2{r_cond & reset}};
  assign Undef      = w_undef & reset;
  assign State      = r_state;
  assign InstrCount = r_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl (CNT_W=4 so the counter wraps). Instructions are
// expanded into per-cycle expected records, driven and queued; a monitor
// pops and compares one record per cycle.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] Op = '0;
  logic [5:0] Funct = '0;
  logic [3:0] Rd = '0;
  logic       CondEx = 1'b0;
  logic       MemReady = 1'b1;
  logic       IRWrite, AdrSrc, PCWrite, RegWrite, MemWrite, Undef;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUControl, FlagWrite;
  logic [3:0] State;
  logic [3:0] InstrCount;

  multicycle_ctrl #(.CNT_W(4), .FETCH_WAIT(1'b1)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .CondEx(CondEx), .MemReady(MemReady), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .FlagWrite(FlagWrite), .Undef(Undef),
    .State(State), .InstrCount(InstrCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    logic       mr, ce;
    logic       irw, adr;
    logic [1:0] sa, sb, rs, ac;
    logic       pcw, rw, mw;
    logic [1:0] fw;
    logic       ud;
    logic [3:0] cnt;
  } cyc_t;

  cyc_t trace[$];
  cyc_t sb_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   m_cnt = 0;
  bit   ce_hi = 1'b0;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic cyc_t blank(input logic [3:0] st);
    cyc_t c;
    c     = '{default: '0};
    c.st  = st;
    c.mr  = 1'($urandom_range(0, 1));
    c.ce  = ce_hi ? 1'b1 : 1'($urandom_range(0, 1));
    c.cnt = m_cnt[3:0];
    return c;
  endfunction

  // Expand one instruction into its expected cycle-by-cycle behaviour
  task automatic gen_instr(input logic [1:0] op, input logic [5:0] fn,
                           input logic [3:0] rd, input logic cond,
                           input int fwait, input int mwait);
    cyc_t       c;
    logic [1:0] ctrl;
    logic       known;
    for (int i = 0; i < fwait; i++) begin
      c = blank(4'd0); c.mr = 1'b0; c.sa = 2'd1; c.sb = 2'd2; c.rs = 2'd2;
      trace.push_back(c);
    end
    c = blank(4'd0); c.mr = 1'b1; c.sa = 2'd1; c.sb = 2'd2; c.rs = 2'd2;
    c.irw = 1'b1; c.pcw = 1'b1;
    trace.push_back(c);
    c = blank(4'd1); c.ce = cond; c.sa = 2'd1; c.sb = 2'd2; c.rs = 2'd2;
    c.ud = (op == 2'd3);
    trace.push_back(c);
    known = 1'b1;
    case (fn[4:1])
      4'b0100: ctrl = 2'd0;
      4'b0010: ctrl = 2'd1;
      4'b0000: ctrl = 2'd2;
      4'b1100: ctrl = 2'd3;
      default: begin ctrl = 2'd0; known = 1'b0; end
    endcase
    if (op == 2'd0) begin
      c = blank(fn[5] ? 4'd7 : 4'd6);
      c.sb = fn[5] ? 2'd1 : 2'd0;
      c.ac = ctrl;
      if (known && cond) c.fw = {fn[0], fn[0] & (ctrl == 2'd0 || ctrl == 2'd1)};
      trace.push_back(c);
      c = blank(4'd8); c.rw = cond; c.pcw = cond && (rd == 4'd15);
      trace.push_back(c);
    end else if (op == 2'd1) begin
      c = blank(4'd2); c.sb = 2'd1;
      trace.push_back(c);
      if (fn[0]) begin
        for (int i = 0; i <= mwait; i++) begin
          c = blank(4'd3); c.adr = 1'b1; c.mr = (i == mwait);
          trace.push_back(c);
        end
        c = blank(4'd4); c.rs = 2'd1; c.rw = cond; c.pcw = cond && (rd == 4'd15);
        trace.push_back(c);
      end else begin
        for (int i = 0; i <= mwait; i++) begin
          c = blank(4'd5); c.adr = 1'b1; c.mw = cond; c.mr = (i == mwait);
          trace.push_back(c);
        end
      end
    end else if (op == 2'd2) begin
      c = blank(4'd9); c.sb = 2'd1; c.rs = 2'd2; c.pcw = cond;
      trace.push_back(c);
    end
    if (op != 2'd3) m_cnt = (m_cnt + 1) % 16;
  endtask

  // Drive up to n queued cycles (n<0: all); entered and left at posedge+1
  task automatic drive(input int n);
    cyc_t c;
    int   k;
    k = 0;
    while (trace.size() > 0 && (n < 0 || k < n)) begin
      c = trace.pop_front();
      MemReady = c.mr;
      CondEx   = c.ce;
      sb_q.push_back(c);
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                     input logic cond, input int fwait, input int mwait);
    Op = op; Funct = fn; Rd = rd;
    gen_instr(op, fn, rd, cond, fwait, mwait);
    drive(-1);
  endtask

  task automatic chk_quiet(input logic [3:0] cnt);
    chk("rst_State", State, 4'd0);
    chk("rst_IRWrite", 4'(IRWrite), 4'd0);
    chk("rst_PCWrite", 4'(PCWrite), 4'd0);
    chk("rst_RegWrite", 4'(RegWrite), 4'd0);
    chk("rst_MemWrite", 4'(MemWrite), 4'd0);
    chk("rst_FlagWrite", 4'(FlagWrite), 4'd0);
    chk("rst_Undef", 4'(Undef), 4'd0);
    chk("rst_InstrCount", InstrCount, cnt);
  endtask

  initial begin : mon
    cyc_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("State", State, e.st);
        chk("IRWrite", 4'(IRWrite), 4'(e.irw));
        chk("AdrSrc", 4'(AdrSrc), 4'(e.adr));
        chk("ALUSrcA", 4'(ALUSrcA), 4'(e.sa));
        chk("ALUSrcB", 4'(ALUSrcB), 4'(e.sb));
        chk("ResultSrc", 4'(ResultSrc), 4'(e.rs));
        chk("ALUControl", 4'(ALUControl), 4'(e.ac));
        chk("PCWrite", 4'(PCWrite), 4'(e.pcw));
        chk("RegWrite", 4'(RegWrite), 4'(e.rw));
        chk("MemWrite", 4'(MemWrite), 4'(e.mw));
        chk("FlagWrite", 4'(FlagWrite), 4'(e.fw));
        chk("Undef", 4'(Undef), 4'(e.ud));
        chk("InstrCount", InstrCount, e.cnt);
      end
    end
  end

  initial begin
    // Reset held for 3 cycles with MemReady high
    reset = 1'b0; MemReady = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_quiet(4'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1;

    // Directed instructions
    run(2'd0, 6'b101001, 4'd3, 1'b1, 0, 0);   // ADDS immediate
    ce_hi = 1'b1;
    run(2'd0, 6'b000101, 4'd2, 1'b0, 0, 0);   // SUBS, condition fails
    ce_hi = 1'b0;
    run(2'd1, 6'b011000, 4'd4, 1'b1, 0, 3);   // STR with 3 wait cycles
    run(2'd1, 6'b011001, 4'd15, 1'b1, 1, 1);  // LDR to PC
    run(2'd2, 6'b100000, 4'd0, 1'b1, 0, 0);   // branch taken
    run(2'd3, 6'b000000, 4'd0, 1'b1, 0, 0);   // undefined
    run(2'd0, 6'b011111, 4'd15, 1'b1, 2, 0);  // unknown ALU code
    run(2'd0, 6'b111000, 4'd15, 1'b1, 0, 0);  // ORR imm to PC, no S

    // Random instructions; enough retirements to wrap the 4-bit counter
    for (int i = 0; i < 150; i++) begin
      run(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
          ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Reset in the middle of an ADDS, right after DECODE with CondEx=1
    Op = 2'd0; Funct = 6'b101001; Rd = 4'd15;
    gen_instr(2'd0, 6'b101001, 4'd15, 1'b1, 0, 0);
    drive(2);
    trace.delete();
    reset = 1'b0;
    #1;
    chk_quiet(4'd0);
    @(posedge clk); @(negedge clk);
    chk_quiet(4'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    m_cnt = 0;
    // Next instruction must start cleanly from FETCH with no stale write
    run(2'd0, 6'b000000, 4'd1, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      run(2'($urandom_range(0, 2)), 6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), $urandom_range(0, 1), $urandom_range(0, 2));
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
